// File: rtl/exp_host_ctrl.sv
// Host-side initiator for montgomery_exp: loads five operands from a word stream,
// pulses the core start, waits for done and streams the latched result back out.
module exp_host_ctrl #(
  parameter int WIDTH = 1024,
  parameter int WORD  = 32,
  parameter int NOPS  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             busy,
  output logic             core_start,
  output logic [WIDTH-1:0] core_R2_modm,
  output logic [WIDTH-1:0] core_R_modm,
  output logic [WIDTH-1:0] core_in_m,
  output logic [WIDTH-1:0] core_d,
  output logic [WIDTH-1:0] core_message,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  output logic [1:0]       dbg_state
);

  localparam int WPO   = WIDTH / WORD;
  localparam int TOTAL = NOPS * WPO;
  localparam int CW    = $clog2(TOTAL);
  localparam int LW    = $clog2(WPO);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WORD-1:0] op_mem  [TOTAL];
  logic [WORD-1:0] res_mem [WPO];

  // Handshake: a word moves on a rising edge where valid && ready are both high.
  // in_ready and out_valid depend only on state (and reset), never on the peer's
  // valid/ready, so no combinational loop can form through this block.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    core_start = 1'b0;
    if (!resetn) begin
      case (state)
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (cnt == CW'(TOTAL - 1)) begin
              cnt_nxt   = '0;
              state_nxt = START;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        START: begin
          core_start = 1'b1;
          busy       = 1'b1;
          state_nxt  = WAIT;
        end
        WAIT: begin
          busy = 1'b1;
          if (core_done) begin
            cnt_nxt   = '0;
            state_nxt = SEND;
          end
        end
        SEND: begin
          out_valid = 1'b1;
          out_data  = res_mem[cnt[LW-1:0]];
          out_last  = (cnt == CW'(WPO - 1));
          if (out_ready) begin
            if (cnt == CW'(WPO - 1)) begin
              cnt_nxt   = '0;
              state_nxt = LOAD;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= LOAD;
      cnt   <= '0;
      for (int i = 0; i < TOTAL; i++) op_mem[i] <= '0;
      for (int j = 0; j < WPO; j++) res_mem[j] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == LOAD && in_valid) op_mem[cnt] <= in_data;
      if (state == WAIT && core_done) begin
        for (int j = 0; j < WPO; j++) res_mem[j] <= core_result[j*WORD +: WORD];
      end
    end
  end

  // Word k of the load stream lands in operand k/WPO, least-significant word first.
  for (genvar j = 0; j < WPO; j++) begin : g_ops
    assign core_R2_modm[j*WORD +: WORD] = op_mem[0*WPO + j];
    assign core_R_modm [j*WORD +: WORD] = op_mem[1*WPO + j];
    assign core_in_m   [j*WORD +: WORD] = op_mem[2*WPO + j];
    assign core_d      [j*WORD +: WORD] = op_mem[3*WPO + j];
    assign core_message[j*WORD +: WORD] = op_mem[4*WPO + j];
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_exp_host_ctrl.sv
// Bench for exp_host_ctrl: directed jobs against a stub core, with a
// transaction-level model checked every cycle plus literal spot checks.
module tb_exp_host_ctrl;

  localparam int WIDTH = 1024;
  localparam int WORD  = 32;
  localparam int WPO   = WIDTH / WORD;
  localparam int TOTAL = 5 * WPO;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WORD-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WORD-1:0]  out_data;
  logic             out_last;
  logic             busy;
  logic             core_start;
  logic [WIDTH-1:0] core_R2_modm, core_R_modm, core_in_m, core_d, core_message;
  logic [WIDTH-1:0] core_result;
  logic             core_done;
  logic [1:0]       dbg_state;

  logic             stub_done  = 1'b0;
  logic             force_done = 1'b0;
  logic [WIDTH-1:0] res_reg    = '0;
  logic [WORD-1:0]  res_base   = '0;
  int               stub_delay = 7;
  int               stub_cnt   = 0;

  int checks = 0;
  int errors = 0;
  bit live   = 1'b0;

  // model state: words loaded this job, start issued, result words still to send
  int               m_loaded  = 0;
  bit               m_started = 1'b0;
  logic [WORD-1:0]  m_ops [TOTAL];
  logic [WORD-1:0]  exp_q [$];

  assign core_done   = stub_done | force_done;
  assign core_result = res_reg;

  exp_host_ctrl #(.WIDTH(WIDTH), .WORD(WORD), .NOPS(5)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .core_start(core_start),
    .core_R2_modm(core_R2_modm), .core_R_modm(core_R_modm), .core_in_m(core_in_m),
    .core_d(core_d), .core_message(core_message),
    .core_result(core_result), .core_done(core_done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_wide(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 0; j < WPO; j++) begin
        if (act[j*WORD +: WORD] !== exp[j*WORD +: WORD]) begin
          $display("FAIL %s word%0d act=%h exp=%h t=%0t", name, j,
                   act[j*WORD +: WORD], exp[j*WORD +: WORD], $time);
          break;
        end
      end
    end
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    errors++;
    $display("FAIL %s timeout act=none exp=event", name);
    report();
  endtask

  function automatic logic [WIDTH-1:0] m_op(input int k);
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WPO; j++) r[j*WORD +: WORD] = m_ops[k*WPO + j];
    return r;
  endfunction

  // model: advances one job phase per edge from the inputs seen at that edge
  always @(posedge clk) begin
    if (resetn === 1'b1) begin
      m_loaded  = 0;
      m_started = 1'b0;
      exp_q.delete();
      for (int i = 0; i < TOTAL; i++) m_ops[i] = '0;
    end else if (m_loaded < TOTAL) begin
      if (in_valid) begin
        m_ops[m_loaded] = in_data;
        m_loaded++;
      end
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (exp_q.size() == 0) begin
      if (core_done) for (int j = 0; j < WPO; j++) exp_q.push_back(core_result[j*WORD +: WORD]);
    end else if (out_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_loaded  = 0;
        m_started = 1'b0;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (live) begin
      if (resetn) begin
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
      end else begin
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, m_loaded < TOTAL});
        chk("m_core_start", {31'd0, core_start}, {31'd0, (m_loaded == TOTAL) && !m_started});
        chk("m_busy", {31'd0, busy}, {31'd0, (m_loaded == TOTAL) && (exp_q.size() == 0)});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
          chk("m_out_data", out_data, exp_q[0]);
          chk("m_out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
        end
      end
      chk_wide("m_R2_modm", core_R2_modm, m_op(0));
      chk_wide("m_R_modm", core_R_modm, m_op(1));
      chk_wide("m_in_m", core_in_m, m_op(2));
      chk_wide("m_d", core_d, m_op(3));
      chk_wide("m_message", core_message, m_op(4));
    end
  end

  // stub core: done pulse stub_delay cycles after start, result word j = res_base + j
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      stub_cnt  = 0;
      stub_done = 1'b0;
    end else begin
      if (stub_done) begin
        stub_done = 1'b0;
        chk("valid_after_done", {31'd0, out_valid}, 32'd1);
      end
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          for (int j = 0; j < WPO; j++) res_reg[j*WORD +: WORD] = res_base + WORD'(j);
          stub_done = 1'b1;
          chk("valid_before_done", {31'd0, out_valid}, 32'd0);
        end
      end
      if (core_start === 1'b1) stub_cnt = stub_delay;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: stream one 160-word job, optionally pulsing a stray done in LOAD and START
  task automatic load_job(input logic [WORD-1:0] base, input bit spurious);
    logic r;
    int   n;
    for (int i = 0; i < TOTAL; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = base + WORD'(i);
      if (spurious && i == 10) force_done = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        r = in_ready;
        tick();
        n++;
        if (n > 50) timeout_fail("load_accept");
      end while (!r);
      force_done = 1'b0;
    end
    in_valid = 1'b0;
    chk("start_after_last", {31'd0, core_start}, 32'd1);
    chk("busy_in_start", {31'd0, busy}, 32'd1);
    chk("r2_lo", core_R2_modm[31:0], base);
    chk("r2_hi", core_R2_modm[1023:992], base + 32'd31);
    chk("msg_lo", core_message[31:0], base + 32'd128);
    chk("msg_hi", core_message[1023:992], base + 32'd159);
    if (spurious) force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("start_one_cycle", {31'd0, core_start}, 32'd0);
    chk("busy_in_wait", {31'd0, busy}, 32'd1);
  endtask

  // driver: drain the result, with optional backpressure word and mid-send reset
  task automatic recv_job(input logic [WORD-1:0] rbase, input int bp_word, input int abort_word);
    int n;
    out_ready = 1'b1;
    for (int w = 0; w < WPO; w++) begin
      n = 0;
      forever begin
        @(negedge clk);
        if (out_valid) break;
        n++;
        if (n > 100) timeout_fail("recv_valid");
      end
      chk("out_word", out_data, rbase + WORD'(w));
      chk("out_last_flag", {31'd0, out_last}, {31'd0, w == WPO - 1});
      if (w == abort_word) begin
        #1 resetn = 1'b1;
        tick();
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_core_start", {31'd0, core_start}, 32'd0);
        resetn = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk_wide("abort_r2", core_R2_modm, '0);
        chk_wide("abort_d", core_d, '0);
        chk_wide("abort_msg", core_message, '0);
        return;
      end
      if (w == bp_word) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_data", out_data, rbase + WORD'(w));
          chk("bp_last", {31'd0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    chk("ready_after_last", {31'd0, in_ready}, 32'd1);
    chk("valid_after_last", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    resetn    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    live = 1'b1;
    tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk_wide("reset_d", core_d, '0);
    resetn = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // job 1: incrementing load, inputs ignored while waiting, result word j = j
    stub_delay = 30;
    res_base   = 32'h0;
    load_job(32'h0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (20) begin
      @(negedge clk);
      chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("wait_r2_kept", core_R2_modm[31:0], 32'h0);
    chk("wait_msg_kept", core_message[1023:992], 32'd159);
    recv_job(32'h0, -1, -1);

    // job 2: stray done pulses, backpressure on word 5
    stub_delay = 7;
    res_base   = 32'h100;
    load_job(32'h1000, 1'b1);
    recv_job(32'h100, 5, -1);

    // job 3: reset while word 10 is on the output
    res_base = 32'h2000_0000;
    load_job(32'h5000, 1'b0);
    recv_job(32'h2000_0000, -1, 10);

    // job 4: fresh full job after the abort
    res_base = 32'hA000_0000;
    load_job(32'h9000, 1'b0);
    recv_job(32'hA000_0000, 2, -1);

    repeat (3) tick();
    report();
  end

  initial begin
    #200000;
    timeout_fail("global");
  end

endmodule
